multicycle_control: RTL

Multi-cycle MIPS control unit. It is the sequential successor to the combinational single-cycle decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and emits per-state datapath strobes.
- Waits on a memory-ready handshake, with a parametrised timeout.
- Supports halt/step from the debug unit.
- Sits between the instruction register (IR, external) and the shared-memory datapath.

---
 rtl/control_pkg.sv | 75 +++++++
 rtl/control_class_decode.sv | 54 +++++
 rtl/multicycle_control.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, functs,
// FSM states, datapath select codes and the instruction class enum.
package control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_LWU   = 6'b100111;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_ERROR
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_RFN = 2'b10;
    localparam logic [1:0] ALU_IFN = 2'b11;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;
    localparam logic [1:0] W_NA   = 2'b11;

    typedef enum logic [3:0] {
        CL_R, CL_JR, CL_JALR, CL_J, CL_JAL, CL_BR, CL_IALU, CL_LOAD, CL_STORE, CL_ILLEGAL
    } iclass_t;

endpackage

// File: rtl/control_class_decode.sv
// Combinational opcode/funct classifier: instruction class plus the memory
// access width and signedness that travel with it.
module control_class_decode
    import control_pkg::*;
#(
    parameter int NB_OP = 6
) (
    input  logic [NB_OP-1:0] i_opcode,
    input  logic [NB_OP-1:0] i_funct,
    output iclass_t          o_class,
    output logic [1:0]       o_width,
    output logic             o_sign_flag,
    output logic             o_illegal
);

    always_comb begin
        o_class     = CL_ILLEGAL;
        o_width     = W_NA;
        o_sign_flag = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_JR:   o_class = CL_JR;
                    FN_JALR: o_class = CL_JALR;
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT, FN_SLTU: o_class = CL_R;
                    default: o_class = CL_ILLEGAL;
                endcase
            end
            OP_J:   o_class = CL_J;
            OP_JAL: o_class = CL_JAL;
            OP_BEQ, OP_BNE: o_class = CL_BR;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: o_class = CL_IALU;
            OP_ADDIU, OP_SLTIU, OP_LUI: begin
                o_class     = CL_IALU;
                o_sign_flag = 1'b1;
            end
            OP_LB:  begin o_class = CL_LOAD;  o_width = W_BYTE; end
            OP_LH:  begin o_class = CL_LOAD;  o_width = W_HALF; end
            OP_LW:  begin o_class = CL_LOAD;  o_width = W_WORD; end
            OP_LBU: begin o_class = CL_LOAD;  o_width = W_BYTE; o_sign_flag = 1'b1; end
            OP_LHU: begin o_class = CL_LOAD;  o_width = W_HALF; o_sign_flag = 1'b1; end
            OP_LWU: begin o_class = CL_LOAD;  o_width = W_WORD; o_sign_flag = 1'b1; end
            OP_SB:  begin o_class = CL_STORE; o_width = W_BYTE; end
            OP_SH:  begin o_class = CL_STORE; o_width = W_HALF; end
            OP_SW:  begin o_class = CL_STORE; o_width = W_WORD; end
            default: o_class = CL_ILLEGAL;
        endcase
    end

    assign o_illegal = (o_class == CL_ILLEGAL);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, memory
// ready handshake with timeout, debug halt at instruction boundaries.
module multicycle_control
    import control_pkg::*;
#(
    parameter int NB_OP       = 6,
    parameter int NB_STATE    = 3,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                i_reset,
    input  logic [NB_OP-1:0]    i_opcode,
    input  logic [NB_OP-1:0]    i_funct,
    input  logic                i_mem_ready,
    input  logic                i_halt,
    output logic [NB_STATE-1:0] o_state,
    output logic                o_pc_write,
    output logic                o_pc_write_cond,
    output logic                o_branch_ne,
    output logic [1:0]          o_pc_src,
    output logic                o_ir_write,
    output logic                o_iord,
    output logic                o_mem_read,
    output logic                o_mem_write,
    output logic [1:0]          o_width,
    output logic                o_sign_flag,
    output logic                o_alu_src_a,
    output logic [1:0]          o_alu_src_b,
    output logic [1:0]          o_alu_op,
    output logic                o_reg_write,
    output logic                o_reg_dst,
    output logic                o_mem2reg,
    output logic                o_link,
    output logic                o_instr_done,
    output logic                o_illegal,
    output logic                o_halted,
    output logic                o_error
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t           r_state;
    state_t           w_next;
    state_t           w_boundary;
    logic [CNT_W-1:0] r_wait_cnt;
    iclass_t          w_class;
    logic [1:0]       w_width;
    logic             w_sign;
    logic             w_illegal;
    logic             w_waiting;
    logic             w_timeout;

    control_class_decode #(.NB_OP(NB_OP)) u_class_decode (
        .i_opcode    (i_opcode),
        .i_funct     (i_funct),
        .o_class     (w_class),
        .o_width     (w_width),
        .o_sign_flag (w_sign),
        .o_illegal   (w_illegal)
    );

    assign w_waiting  = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !i_mem_ready;
    assign w_boundary = i_halt ? ST_IDLE : ST_FETCH;

    // Timeout fires on the MEM_TIMEOUT-th consecutive wait cycle; a ready in
    // that same cycle never reaches here because w_waiting is then low.
    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            assign w_timeout = w_waiting && (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait_cnt <= '0;
            else if (w_waiting)
                r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (!i_halt) w_next = ST_FETCH;
            ST_FETCH:  begin
                if (i_mem_ready)    w_next = ST_DECODE;
                else if (w_timeout) w_next = ST_ERROR;
            end
            ST_DECODE: w_next = w_illegal ? w_boundary : ST_EXEC;
            ST_EXEC:   begin
                case (w_class)
                    CL_R, CL_IALU:     w_next = ST_WB;
                    CL_LOAD, CL_STORE: w_next = ST_MEM;
                    default:           w_next = w_boundary;
                endcase
            end
            ST_MEM:    begin
                if (i_mem_ready)    w_next = (w_class == CL_LOAD) ? ST_WB : w_boundary;
                else if (w_timeout) w_next = ST_ERROR;
            end
            ST_WB:     w_next = w_boundary;
            ST_ERROR:  w_next = ST_ERROR;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_branch_ne     = 1'b0;
        o_pc_src        = PC_PLUS4;
        o_ir_write      = 1'b0;
        o_iord          = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_width         = W_NA;
        o_sign_flag     = 1'b0;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = SRCB_RT;
        o_alu_op        = ALU_ADD;
        o_reg_write     = 1'b0;
        o_reg_dst       = 1'b0;
        o_mem2reg       = 1'b0;
        o_link          = 1'b0;
        o_instr_done    = 1'b0;
        o_illegal       = 1'b0;
        o_halted        = 1'b0;
        o_error         = 1'b0;
        case (r_state)
            ST_IDLE:   o_halted = 1'b1;
            ST_FETCH:  begin
                o_mem_read  = 1'b1;
                o_alu_src_b = SRCB_FOUR;
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
            end
            ST_DECODE: begin
                o_alu_src_b  = SRCB_IMMSH2;
                o_illegal    = w_illegal;
                o_instr_done = w_illegal;
            end
            ST_EXEC:   begin
                case (w_class)
                    CL_R: begin
                        o_alu_src_a = 1'b1;
                        o_alu_op    = ALU_RFN;
                    end
                    CL_JR, CL_JALR: begin
                        o_pc_write   = 1'b1;
                        o_pc_src     = PC_RS;
                        o_reg_write  = (w_class == CL_JALR);
                        o_link       = (w_class == CL_JALR);
                        o_instr_done = 1'b1;
                    end
                    CL_J, CL_JAL: begin
                        o_pc_write   = 1'b1;
                        o_pc_src     = PC_JUMP;
                        o_reg_write  = (w_class == CL_JAL);
                        o_link       = (w_class == CL_JAL);
                        o_instr_done = 1'b1;
                    end
                    CL_BR: begin
                        o_alu_src_a     = 1'b1;
                        o_alu_op        = ALU_SUB;
                        o_pc_write_cond = 1'b1;
                        o_pc_src        = PC_BRANCH;
                        o_branch_ne     = (i_opcode == OP_BNE);
                        o_instr_done    = 1'b1;
                    end
                    CL_IALU: begin
                        o_alu_src_a = 1'b1;
                        o_alu_src_b = SRCB_IMM;
                        o_alu_op    = ALU_IFN;
                        o_sign_flag = w_sign;
                    end
                    CL_LOAD, CL_STORE: begin
                        o_alu_src_a = 1'b1;
                        o_alu_src_b = SRCB_IMM;
                    end
                    default: ;
                endcase
            end
            ST_MEM:    begin
                o_iord       = 1'b1;
                o_width      = w_width;
                o_sign_flag  = w_sign;
                o_mem_read   = (w_class == CL_LOAD);
                o_mem_write  = (w_class == CL_STORE);
                o_instr_done = (w_class == CL_STORE) && i_mem_ready;
            end
            ST_WB:     begin
                o_reg_write  = 1'b1;
                o_reg_dst    = (w_class != CL_R);
                o_instr_done = 1'b1;
                if (w_class == CL_LOAD) begin
                    o_mem2reg   = 1'b1;
                    o_width     = w_width;
                    o_sign_flag = w_sign;
                end
            end
            ST_ERROR:  o_error = 1'b1;
            default: ;
        endcase
    end

    assign o_state = NB_STATE'(r_state);

endmodule
